// File: rtl/fp32div_if.sv
// Operand/result handshake bundle for the fp32div divider.
// The master issues x1/x2 with an en pulse; the slave answers with y and a ready pulse.
interface fp32div_if;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        en;
  logic [31:0] y;
  logic        ready;

  modport master (output x1, output x2, output en, input y, input ready);
  modport slave  (input x1, input x2, input en, output y, output ready);
endinterface

// File: rtl/fp32div.sv
// Multi-cycle binary32 divider: radix-2 restoring mantissa division, one quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to zero on input and output.
module fp32div (
  input  logic       clk,
  input  logic       rst,
  fp32div_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DIV   = 2'd2,
    S_ROUND = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_x1;
  logic [31:0]        r_x2;
  logic [31:0]        r_y;
  logic               r_ready;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_m2;
  logic [24:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;

  logic [7:0]         w_e1;
  logic [7:0]         w_e2;
  logic [22:0]        w_f1;
  logic [22:0]        w_f2;
  logic               w_sign;
  logic               w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic               w_special;
  logic [31:0]        w_spec_y;
  logic               w_ge;
  logic [23:0]        w_diff;
  logic [23:0]        w_mant;
  logic               w_g;
  logic               w_s;
  logic signed [9:0]  w_e_adj;
  logic [24:0]        w_rnd;
  logic [22:0]        w_mant_f;
  logic signed [9:0]  w_e_fin;
  logic [31:0]        w_res;

  assign w_e1    = r_x1[30:23];
  assign w_e2    = r_x2[30:23];
  assign w_f1    = r_x1[22:0];
  assign w_f2    = r_x2[22:0];
  assign w_sign  = r_x1[31] ^ r_x2[31];
  assign w_zero1 = (w_e1 == 8'h00);
  assign w_zero2 = (w_e2 == 8'h00);
  assign w_inf1  = (w_e1 == 8'hFF) && (w_f1 == 23'h0);
  assign w_inf2  = (w_e2 == 8'hFF) && (w_f2 == 23'h0);
  assign w_nan1  = (w_e1 == 8'hFF) && (w_f1 != 23'h0);
  assign w_nan2  = (w_e2 == 8'hFF) && (w_f2 != 23'h0);

  // Special-operand classification in priority order
  always_comb begin
    w_special = 1'b1;
    w_spec_y  = 32'h0;
    if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
      w_spec_y = 32'h7FC0_0000;
    end else if (w_inf1) begin
      w_spec_y = {w_sign, 8'hFF, 23'h0};
    end else if (w_inf2) begin
      w_spec_y = {w_sign, 31'h0};
    end else if (w_zero2) begin
      w_spec_y = {w_sign, 8'hFF, 23'h0};
    end else if (w_zero1) begin
      w_spec_y = {w_sign, 31'h0};
    end else begin
      w_special = 1'b0;
      w_spec_y  = 32'h0;
    end
  end

  // One restoring-division step; the partial remainder stays below 2*m2, so it fits 25 bits
  always_comb begin
    w_ge = (r_rem >= {1'b0, r_m2});
    if (w_ge) begin
      w_diff = r_rem[23:0] - r_m2;
    end else begin
      w_diff = r_rem[23:0];
    end
  end

  // Normalise, round to nearest even and clamp the exponent range
  always_comb begin
    w_e_adj = r_exp;
    if (r_q[25]) begin
      w_mant = r_q[25:2];
      w_g    = r_q[1];
      w_s    = r_q[0] | (r_rem != 25'd0);
    end else begin
      w_mant  = r_q[24:1];
      w_g     = r_q[0];
      w_s     = (r_rem != 25'd0);
      w_e_adj = r_exp - 10'sd1;
    end
    w_rnd = {1'b0, w_mant} + {24'd0, (w_g & (w_s | w_mant[0]))};
    if (w_rnd[24]) begin
      w_mant_f = w_rnd[23:1];
      w_e_fin  = w_e_adj + 10'sd1;
    end else begin
      w_mant_f = w_rnd[22:0];
      w_e_fin  = w_e_adj;
    end
    if (w_e_fin >= 10'sd255) begin
      w_res = {r_sign, 8'hFF, 23'h0};
    end else if (w_e_fin <= 10'sd0) begin
      w_res = {r_sign, 31'h0};
    end else begin
      w_res = {r_sign, w_e_fin[7:0], w_mant_f};
    end
  end

  // Sequencer: IDLE -> CHECK -> (DIV x26 -> ROUND) -> IDLE, with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x1    <= 32'h0;
      r_x2    <= 32'h0;
      r_y     <= 32'h0;
      r_ready <= 1'b0;
      r_sign  <= 1'b0;
      r_exp   <= 10'sd0;
      r_m2    <= 24'h0;
      r_rem   <= 25'h0;
      r_q     <= 26'h0;
      r_cnt   <= 5'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.en) begin
            r_x1    <= bus.x1;
            r_x2    <= bus.x2;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_y     <= w_spec_y;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_exp   <= $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + 10'sd127;
            r_m2    <= {1'b1, w_f2};
            r_rem   <= {2'b01, w_f1};
            r_q     <= 26'h0;
            r_cnt   <= 5'd0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_rem <= {w_diff, 1'b0};
          r_q   <= {r_q[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd25) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_y     <= w_res;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.y     = r_y;
  assign bus.ready = r_ready;

endmodule

// File: tb/tb_fp32div.sv
// Self-checking bench for fp32div: directed cases plus randomized operands against an
// integer-arithmetic reference of binary32 division (RNE, flush-to-zero).
module tb_fp32div;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fp32div_if bus ();

  fp32div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact quotient with 40 extra fraction bits, then round-to-nearest-even.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output bit special);
    logic [7:0]      e1, e2;
    logic [22:0]     f1, f2;
    logic            s;
    bit              z1, z2, i1, i2, n1, n2;
    longint unsigned m1, m2, num, q, r, mant, low, half;
    int              e, sh;
    bit              up;
    e1 = a[30:23]; e2 = b[30:23]; f1 = a[22:0]; f2 = b[22:0];
    s  = a[31] ^ b[31];
    z1 = (e1 == 8'h00); z2 = (e2 == 8'h00);
    i1 = (e1 == 8'hFF) && (f1 == 23'h0); i2 = (e2 == 8'hFF) && (f2 == 23'h0);
    n1 = (e1 == 8'hFF) && (f1 != 23'h0); n2 = (e2 == 8'hFF) && (f2 != 23'h0);
    special = 1'b1;
    y = 32'h0;
    if (n1 || n2 || (z1 && z2) || (i1 && i2)) y = 32'h7FC0_0000;
    else if (i1) y = {s, 8'hFF, 23'h0};
    else if (i2) y = {s, 31'h0};
    else if (z2) y = {s, 8'hFF, 23'h0};
    else if (z1) y = {s, 31'h0};
    else begin
      special = 1'b0;
      m1  = 64'h80_0000 + 64'(f1);
      m2  = 64'h80_0000 + 64'(f2);
      num = m1 << 40;
      q   = num / m2;
      r   = num % m2;
      e   = int'(e1) - int'(e2) + 127;
      if (q >= (64'd1 << 40)) sh = 17;
      else begin sh = 16; e = e - 1; end
      mant = q >> sh;
      low  = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (low > half) || ((low == half) && ((r != 64'd0) || mant[0]));
      mant = mant + (up ? 64'd1 : 64'd0);
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) y = {s, 8'hFF, 23'h0};
      else if (e <= 0) y = {s, 31'h0};
      else y = {s, e[7:0], mant[22:0]};
    end
  endfunction

  // Issue one operation (en held for exactly one edge), scramble inputs afterwards and
  // report the result and the number of edges from acceptance to ready (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int k;
    bus.x1 = a;
    bus.x2 = b;
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    bus.x1 = $urandom;
    bus.x2 = $urandom;
    lat = -1;
    k   = 0;
    while (lat < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (bus.ready === 1'b1) lat = k;
    end
    res = bus.y;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.en = 1'b0; bus.x1 = 32'h0; bus.x2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.y !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h expected %h", bus.y, 32'h0); end
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [31:0] res;
    int lat;
    run_op(32'h4040_0000, 32'h4000_0000, res, lat);
    n_checks++;
    if (res !== 32'h3FC0_0000) begin n_fail++; $display("FAIL basic_y: got %h expected %h", res, 32'h3FC0_0000); end
    n_checks++;
    if (lat !== 28) begin n_fail++; $display("FAIL basic_latency: got %0d expected 28", lat); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_pulse: got %b expected 0", bus.ready); end
    n_checks++;
    if (bus.y !== 32'h3FC0_0000) begin n_fail++; $display("FAIL basic_y_hold: got %h expected %h", bus.y, 32'h3FC0_0000); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int lat;
    run_op(32'hC070_0000, 32'h3FC0_0000, res, lat);
    n_checks++;
    if (res !== 32'hC020_0000 || lat !== 28) begin
      n_fail++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 28", res, lat, 32'hC020_0000);
    end
    run_op(32'h4140_0000, 32'hC080_0000, res, lat);
    n_checks++;
    if (res !== 32'hC040_0000 || lat !== 28) begin
      n_fail++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 28", res, lat, 32'hC040_0000);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rounding;
    logic [31:0] res;
    int lat;
    run_op(32'h3F80_0000, 32'h4040_0000, res, lat);
    n_checks++;
    if (res !== 32'h3EAA_AAAB) begin n_fail++; $display("FAIL round_one_third: got %h expected %h", res, 32'h3EAA_AAAB); end
    @(posedge clk); #1;
    run_op(32'h3F80_0000, 32'h3F80_0000, res, lat);
    n_checks++;
    if (res !== 32'h3F80_0000) begin n_fail++; $display("FAIL round_exact_one: got %h expected %h", res, 32'h3F80_0000); end
    @(posedge clk); #1;
  endtask

  task automatic test_specials;
    logic [31:0] ta [6] = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0040_0000, 32'h7F7F_FFFF, 32'h0080_0000};
    logic [31:0] tb [6] = '{32'h0000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h4B00_0000};
    logic [31:0] te [6] = '{32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};
    int          tl [6] = '{1, 1, 1, 1, 28, 28};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], res, lat);
      n_checks++;
      if (res !== te[i] || lat !== tl[i]) begin
        n_fail++;
        $display("FAIL special_%0d: %h/%h got %h lat %0d expected %h lat %0d", i, ta[i], tb[i], res, lat, te[i], tl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] res;
    int lat;
    bit seen;
    run_op(32'h4040_0000, 32'h4000_0000, res, lat);
    @(posedge clk); #1;
    bus.x1 = 32'h3F80_0000; bus.x2 = 32'h4040_0000; bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.y !== 32'h0) begin n_fail++; $display("FAIL midreset_y: got %h expected %h", bus.y, 32'h0); end
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", bus.ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ready: got %b expected 0", seen); end
    run_op(32'h4040_0000, 32'h4000_0000, res, lat);
    n_checks++;
    if (res !== 32'h3FC0_0000 || lat !== 28) begin
      n_fail++; $display("FAIL midreset_fresh: got %h lat %0d expected %h lat 28", res, lat, 32'h3FC0_0000);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [31:0] a, b, res, exp_y;
    logic [7:0]  ea, eb;
    bit          special;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom;
      ea = 8'($urandom_range(1, 254));
      eb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
      if ($urandom_range(0, 1) == 0) ea = 8'($urandom_range(100, 154));
      if ($urandom_range(0, 15) == 0) ea = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 15) == 0) eb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 7) == 0) b[22:0] = a[22:0];
      a[30:23] = ea; b[30:23] = eb;
      ref_div(a, b, exp_y, special);
      run_op(a, b, res, lat);
      n_checks++;
      if (res !== exp_y || lat !== (special ? 1 : 28)) begin
        n_fail++;
        $display("FAIL random_%0d: %h/%h got %h lat %0d expected %h lat %0d", i, a, b, res, lat, exp_y, special ? 1 : 28);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_rounding;
    test_specials;
    test_mid_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32div.md
Name: fp32div

Overview:
- Multi-cycle IEEE-754 binary32 divider, y = x1 / x2.
- Companion to the fp32mult multiplier; same operand/result handshake (en pulse in, ready pulse out), so the two units are interchangeable behind the same datapath sequencer.
- Mantissa quotient is computed by a radix-2 restoring division, one quotient bit per cycle.
- Round-to-nearest-even; subnormals are flushed to zero on both input and output.

Parameters:
- None. Format is fixed at binary32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- x1  input  32  dividend (binary32); sampled on the edge where en is accepted
- x2  input  32  divisor (binary32); sampled with x1
- en  input  1  start request; accepted only in IDLE
- y  output  32  quotient; registered; holds its value until the next result is written
- ready  output  1  one-cycle pulse coincident with a new y

Behaviour:
- Reset (async, rst=1): state=IDLE, y=32'h0, ready=0, internal counters and registers cleared. A reset mid-operation discards the operation; no ready is produced for it.
- States: IDLE, CHECK, DIV, ROUND.
- IDLE: on edge N with en=1, latch x1/x2 and go to CHECK. en is ignored in every other state, and x1/x2 changes after edge N have no effect.
- CHECK (edge N+1):
  - Unpack sign s = s1^s2, exponents, and mantissas with the hidden bit.
  - An input with exp=0 is zero (subnormals treated as zero).
  - If a special case applies, write y, ready<=1, and return to IDLE. Otherwise load remainder=m1, count=0, and go to DIV.
- Special cases, in priority order:
  - Either input NaN, 0/0, or inf/inf -> 32'h7FC00000.
  - inf/finite -> {s,8'hFF,23'h0}.
  - finite/inf -> {s,31'h0}.
  - nonzero/0 -> {s,8'hFF,23'h0}.
  - 0/nonzero -> {s,31'h0}.
- DIV (edges N+2..N+27):
  - 26 iterations produce q[25:0] = floor(m1*2^25 / m2).
  - Each iteration: if rem >= m2, then rem = rem - m2 and qbit = 1; shift rem left 1.
  - After count reaches 25, go to ROUND.
- ROUND (edge N+28):
  - Exponent is signed 10-bit: e = e1 - e2 + 127.
  - If q[25]=1: mant = q[25:2], G = q[1], S = q[0] | (rem != 0).
  - Else: mant = q[24:1], G = q[0], S = (rem != 0), and e = e - 1.
  - Round up when G & (S | mant[0]). If the mantissa overflows to 2^24: mant >>= 1, e = e + 1.
  - If e >= 255: y = {s,8'hFF,23'h0}.
  - If e <= 0: y = {s,31'h0} (flush to zero).
  - Otherwise: y = {s, e[7:0], mant[22:0]}.
  - ready<=1; go to IDLE.
- Latency:
  - Normal operands: ready rises on edge N+28.
  - Special cases: ready rises on edge N+1.
  - ready is always deasserted on the following edge.
- Back-to-back: en=1 in the cycle where ready=1 is accepted, because the state is already IDLE.
- No busy output. Callers must wait for ready before issuing the next en.

Test Plan:
- 3.0/2.0 (40400000 / 40000000), en for one cycle -> y=3FC00000; ready high exactly one cycle, rising on edge N+28.
- -3.75/1.5 (C0700000 / 3FC00000) -> C0200000. Then 12.0/-4.0 (41400000 / C0800000), with en issued during the ready cycle -> C0400000.
- 1.0/3.0 (3F800000 / 40400000) -> 3EAAAAAB (round-up path). Then 1.0/1.0 -> 3F800000 (q[25] path, exact result).
- Specials, each with ready on edge N+1:
  - 3F800000/00000000 -> 7F800000
  - 00000000/00000000 -> 7FC00000
  - 7F800000/BF800000 -> FF800000
  - 00400000 (subnormal)/3F800000 -> 00000000
- Range limits:
  - 7F7FFFFF/3F000000 -> 7F800000 (overflow).
  - 00800000/4B000000 -> 00000000 (underflow flushed to zero).
- Reset in the middle of DIV (edge N+10):
  - y=0 and ready=0 immediately (async).
  - No ready follows.
  - A fresh 40400000/40000000 after reset -> 3FC00000.
